// File: rtl/float_addsub_scheduler_pkg.sv
// Shared constants and the IEEE-754 single-precision add used by the adder model.
// Operands are round-to-nearest-even; subnormals are flushed to signed zero.
package float_addsub_scheduler_pkg;

    localparam logic FSCH_OP_ADD     = 1'b0;
    localparam logic FSCH_OP_SUB     = 1'b1;
    localparam int   FSCH_FP_ADD_LAT = 5;

    function automatic logic [31:0] fp_add_fn(logic [31:0] x, logic [31:0] y);
        logic [31:0] big, sml;
        logic [26:0] mb, ms;
        logic [27:0] sum;
        logic [24:0] rnd;
        logic        sign, sticky, up;
        int          e, d;
        if (x[30:23] == 8'hFF) return x;
        if (y[30:23] == 8'hFF) return y;
        if (x[30:0] >= y[30:0]) begin
            big = x; sml = y;
        end else begin
            big = y; sml = x;
        end
        mb = (big[30:23] == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
        ms = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
        if (mb == 27'd0) return {big[31] & sml[31], 31'd0};
        if (ms == 27'd0) return big;
        sign = big[31];
        e    = int'(big[30:23]);
        d    = e - int'(sml[30:23]);
        // Guard/round/sticky live in the three low bits of the 27-bit mantissas.
        if (d > 26) begin
            ms = 27'd1;
        end else begin
            sticky = |(ms & ((27'd1 << d) - 27'd1));
            ms     = (ms >> d) | {26'd0, sticky};
        end
        if (big[31] == sml[31]) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 1;
            end
        end else begin
            sum = {1'b0, mb - ms};
            if (sum == 28'd0) return 32'd0;
            for (int k = 0; k < 26; k++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
            end
        end
        if (e <= 0) return {sign, 31'd0};
        up  = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd = {1'b0, sum[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {sign, 8'hFF, 23'd0};
        return {sign, e[7:0], rnd[22:0]};
    endfunction

endpackage

// File: rtl/float_addsub_scheduler_if.sv
// Requester/response bundle between FU clusters and the shared FP add/sub scheduler.
interface float_addsub_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    // Handshake: request i transfers in a cycle where req_valid[i] & req_ready[i];
    // req_valid never waits on req_ready, and rsp_valid is not backpressured.
    logic                    enable;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_op;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    busy;

    modport master (
        output enable, req_valid, req_op, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  enable, req_valid, req_op, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/float_addsub_scheduler_fp_add.sv
// Pipelined single-precision adder: result of inputs sampled at an edge appears LATENCY edges later.
module iob_fp_add
    import float_addsub_scheduler_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = FSCH_FP_ADD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic [DATA_W-1:0] res_o
);
    if (DATA_W != 32) begin : g_bad_width
        $error("iob_fp_add supports only DATA_W=32");
    end

    logic [LATENCY-1:0][DATA_W-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = fp_add_fn(op_a_i, op_b_i);
        for (int k = 1; k < LATENCY; k++) pipe_d[k] = pipe_q[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
    end

    assign res_o = pipe_q[LATENCY-1];
endmodule

// File: rtl/float_addsub_scheduler_rr_arbiter.sv
// Round-robin search of req starting at ptr; grants the first hit as one-hot plus index.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/float_addsub_scheduler.sv
// Shares one pipelined FP adder among N_REQ requesters; a tag pipeline routes each result
// back to its issuer exactly LATENCY cycles after the grant.
module float_addsub_scheduler
    import float_addsub_scheduler_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_REQ   = 4,
    parameter int LATENCY = 5,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic clk,
    input  logic rst,
    float_addsub_scheduler_if.slave bus
);
    if (LATENCY != FSCH_FP_ADD_LAT) begin : g_bad_latency
        $error("LATENCY must match the iob_fp_add pipeline depth");
    end

    logic [N_REQ-1:0]  arb_req, gnt;
    logic [ID_W-1:0]   gnt_id, ptr_q, ptr_d;
    logic              gnt_any, is_sub, issue_zero;
    logic [DATA_W-1:0] add_a, add_b, b_raw, add_res;

    logic [LATENCY-1:0]           vld_q, vld_d, zero_q, zero_d;
    logic [LATENCY-1:0][ID_W-1:0] id_q, id_d;

    assign arb_req = bus.enable ? bus.req_valid : '0;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .req     (arb_req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign bus.req_ready = gnt;

    always_comb begin
        add_a      = '0;
        add_b      = '0;
        b_raw      = '0;
        is_sub     = 1'b0;
        issue_zero = 1'b0;
        ptr_d      = ptr_q;
        if (gnt_any) begin
            add_a  = bus.req_a[int'(gnt_id)*DATA_W +: DATA_W];
            b_raw  = bus.req_b[int'(gnt_id)*DATA_W +: DATA_W];
            is_sub = (bus.req_op[gnt_id] == FSCH_OP_SUB);
            add_b  = b_raw;
            if (is_sub) add_b[DATA_W-1] = ~b_raw[DATA_W-1];
            // x - x must be +0 regardless of how the adder signs an exact cancellation.
            issue_zero = is_sub && (add_a == b_raw);
            ptr_d = (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
        end
    end

    iob_fp_add #(.DATA_W(DATA_W), .LATENCY(LATENCY)) u_add (
        .clk    (clk),
        .rst    (rst),
        .op_a_i (add_a),
        .op_b_i (add_b),
        .res_o  (add_res)
    );

    always_comb begin
        vld_d     = vld_q;
        id_d      = id_q;
        zero_d    = zero_q;
        vld_d[0]  = gnt_any;
        id_d[0]   = gnt_id;
        zero_d[0] = issue_zero;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k]  = vld_q[k-1];
            id_d[k]   = id_q[k-1];
            zero_d[k] = zero_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            vld_q  <= '0;
            id_q   <= '0;
            zero_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
            zero_q <= zero_d;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (vld_q[LATENCY-1]) begin
            bus.rsp_valid[id_q[LATENCY-1]] = 1'b1;
            if (!zero_q[LATENCY-1]) bus.rsp_data = add_res;
        end
    end

    assign bus.busy = |vld_q;
endmodule

// File: tb/tb_float_addsub_scheduler.sv
// Directed plus randomized checks of the shared FP add/sub scheduler against an integer-valued
// float reference: operands are exact integers, so every a+b / a-b result is exactly representable.
module tb_float_addsub_scheduler;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int L   = 5;
    localparam int IDW = 2;
    localparam int CW  = 16;
    localparam int QW  = CW + IDW + W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_addsub_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();

    float_addsub_scheduler #(.DATA_W(W), .N_REQ(N), .LATENCY(L), .ID_W(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mptr        = 0;
    logic [QW-1:0] exp_q[$];

    logic         en;
    logic [N-1:0] vld;
    logic         op[N];
    int           ia[N];
    int           ib[N];

    function automatic logic [31:0] int_to_fp(int v);
        int m, e;
        logic [31:0] r;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -v : v;
        e = 0;
        for (int k = 0; k < 31; k++) if (m >= (1 << k)) e = k;
        r[31]    = (v < 0);
        r[30:23] = 8'(e + 127);
        r[22:0]  = 23'(m << (23 - e));
        return r;
    endfunction

    function automatic int rand_int();
        int m;
        m = int'($urandom_range(0, 1 << 20));
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    task automatic new_req(int i);
        op[i] = 1'($urandom_range(0, 1));
        ia[i] = rand_int();
        ib[i] = (op[i] && $urandom_range(0, 3) == 0) ? ia[i] : rand_int();
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic tick();
        int g, idx, res;
        logic [N-1:0] er, ev;
        logic [W-1:0] ed;
        bus.enable    = en;
        bus.req_valid = vld;
        for (int i = 0; i < N; i++) begin
            bus.req_op[i]         = op[i];
            bus.req_a[i*W +: W]   = int_to_fp(ia[i]);
            bus.req_b[i*W +: W]   = int_to_fp(ib[i]);
        end
        #1;
        g = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (g < 0 && vld[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = '0;
        ed = '0;
        if (exp_q.size() > 0 && exp_q[0][QW-1 -: CW] == CW'(cyc)) begin
            ev[exp_q[0][W +: IDW]] = 1'b1;
            ed = exp_q[0][W-1:0];
        end
        check("req_ready", 64'(bus.req_ready), 64'(er));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        check("rsp_data",  64'(bus.rsp_data),  64'(ed));
        check("busy",      64'(bus.busy),      64'(exp_q.size() != 0));
        if (ev != '0) void'(exp_q.pop_front());
        if (g >= 0) begin
            res = op[g] ? (ia[g] - ib[g]) : (ia[g] + ib[g]);
            exp_q.push_back({CW'(cyc + L), IDW'(g), int_to_fp(res)});
            mptr = (g + 1) % N;
            new_req(g);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        vld = '0;
        en  = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        mptr = 0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        en  = 1'b0;
        vld = '0;
        for (int i = 0; i < N; i++) new_req(i);
        @(negedge clk);
        do_reset(3);
        en = 1'b1;
        repeat (2) tick();

        // Single add: 1.0 + 2.0 = 3.0 to requester 0.
        ia[0] = 1; ib[0] = 2; op[0] = 1'b0; vld = 4'b0001;
        tick();
        vld = '0;
        repeat (7) tick();

        // Equal subtract: 3.0 - 3.0 gives exact +0 to requester 2.
        ia[2] = 3; ib[2] = 3; op[2] = 1'b1; vld = 4'b0100;
        tick();
        vld = '0;
        repeat (7) tick();

        // Full contention.
        vld = 4'hF;
        repeat (6) tick();
        vld = '0;
        repeat (7) tick();

        // Back-to-back single requester.
        vld = 4'b0010;
        repeat (8) tick();
        vld = '0;
        repeat (7) tick();

        // Enable drop after three grants.
        vld = 4'hF;
        repeat (3) tick();
        en = 1'b0;
        repeat (8) tick();
        vld = '0;
        en  = 1'b1;

        // Reset two cycles after three grants; nothing in flight may come back.
        vld = 4'hF;
        repeat (3) tick();
        vld = '0;
        repeat (2) tick();
        do_reset(2);
        en  = 1'b1;
        vld = 4'hF;
        repeat (3) tick();
        vld = '0;
        repeat (7) tick();

        // Random traffic.
        repeat (400) begin
            vld = N'($urandom_range(0, 15));
            en  = ($urandom_range(0, 7) != 0);
            tick();
        end
        vld = '0;
        en  = 1'b1;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
